// File: rtl/dff_pipe_vr_if.sv
// Valid/ready bundle for dff_pipe_vr: upstream push side, downstream pop side
// and the occupancy count.
interface dff_pipe_vr_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  count
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output count
  );
endinterface

// File: rtl/dff_pipe_vr.sv
// Elastic DEPTH-stage register pipeline with valid/ready and bubble collapse.
// Optional synchronous flush of all valid bits with DFF_PIPE_VR_FLUSH_EN.
module dff_pipe_vr #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input logic          clk,
  input logic          async_rst_n,
`ifdef DFF_PIPE_VR_FLUSH_EN
  input logic          flush,
`endif
  dff_pipe_vr_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [DEPTH-1:0] r;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             flush_w;
  logic             push;
  logic             pop;
  logic             rdy;

`ifdef DFF_PIPE_VR_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // Ready ripples from the output back to stage 0 (intended long path).
  always_comb begin
    rdy = bus.out_ready;
    r   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy  = !v_q[i] || rdy;
      r[i] = rdy;
    end
  end

  assign bus.in_ready  = r[0] && !flush_w;
  assign bus.out_valid = v_q[DEPTH-1];
  assign bus.out_data  = d_q[DEPTH-1];
  assign bus.count     = count_q;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = v_q[DEPTH-1] && bus.out_ready;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (r[0]) begin
      v_d[0] = bus.in_valid;
      d_d[0] = bus.in_data;
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (r[i]) begin
        v_d[i] = v_q[i-1];
        d_d[i] = d_q[i-1];
      end
    end
    // Flush drops occupancy only; payload registers keep their contents.
    if (flush_w) begin
      v_d = '0;
      d_d = d_q;
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush_w)
      count_d = '0;
    else if (push && !pop)
      count_d = count_q + CW'(1);
    else if (pop && !push)
      count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      v_q     <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        d_q[i] <= '0;
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      d_q     <= d_d;
    end
  end
endmodule

// File: doc/dff_pipe_vr.md
# dff_pipe_vr

Parametrised elastic register pipeline: `DEPTH` stages of `WIDTH`-bit enabled flip-flops with a valid/ready handshake and bubble collapsing. It extends the plain enabled DFF into a multi-stage retiming element. Any stage can accept new data when it is empty or when its downstream neighbour drains in the same cycle. It sits on datapath boundaries where registers must be inserted without breaking flow control.

## Interface
- `WIDTH`, 8, payload width in bits; legal range ≥1.
- `DEPTH`, 3, number of register stages; legal range ≥1.
- `CW`, `$clog2(DEPTH+1)`, occupancy counter width; localparam, not overridable.

- `clk` input 1: clock; all state updates on the rising edge.
- `async_rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: upstream offers `in_data`.
- `in_ready` output 1: stage 0 can accept; transfer occurs when `in_valid && in_ready`.
- `in_data` input WIDTH: upstream payload.
- `out_valid` output 1: last stage holds valid data.
- `out_ready` input 1: downstream accepts; transfer occurs when `out_valid && out_ready`.
- `out_data` output WIDTH: last-stage payload.
- `count` output CW: number of stages currently holding valid data, 0..DEPTH.
- `flush` input 1: present only with `DFF_PIPE_VR_FLUSH_EN`.

## Operation
- State per stage i (0..DEPTH-1):
  - `v[i]`: valid bit.
  - `d[i]`: data register.
  - Stage DEPTH-1 drives `out_valid`/`out_data`.
- Ready chain (combinational):
  - `r[DEPTH] = out_ready`.
  - `r[i] = !v[i] || r[i+1]`.
  - `in_ready = r[0]`.
- Stage i update at the clock edge when `r[i]`:
  - `v[i] <= v[i-1]` and `d[i] <= d[i-1]`.
  - Stage 0 source is `in_valid`/`in_data`.
- Stage i with `!r[i]` holds both `v[i]` and `d[i]`.
- Data registers load only when the stage loads (enable semantics); `d[i]` is not cleared when `v[i]` drops.
- `count`:
  - Register; +1 on input transfer only, −1 on output transfer only.
  - Unchanged on both or neither.
  - Never exceeds DEPTH or underflows.
- Ordering is strictly FIFO; no element is dropped or duplicated.
- Reset value of all outputs and state:
  - All `v[i]=0`, all `d[i]=0`.
  - `out_valid=0`, `out_data=0`, `count=0`.
  - `in_ready=1`, since all stages are empty.
- Reset is asynchronous and applies immediately mid-operation; in-flight data is discarded.

## Timing
- Latency: an input accepted at edge N into an empty pipe gives `out_valid=1` after edge N+DEPTH-1, i.e. data appears DEPTH edges after presentation.
- Throughput: 1 transfer/cycle in steady state when `out_ready=1`.
- Full (`count==DEPTH`):
  - `out_ready=0` → `in_ready=0`.
  - `out_ready=1` → `in_ready=1`; simultaneous push and pop, `count` unchanged.
- Bubbles collapse: a gap between stages is filled by the upstream stage moving forward while the output is stalled.
- Stall stability: while `out_valid && !out_ready`, `out_data` holds constant.
- `in_ready` depends combinationally on `out_ready` through the whole chain; this is an intended DEPTH-long path.
- `DEPTH=1` degenerates to a single enabled register with `in_ready = !v[0] || out_ready`.

## Configuration
- `DFF_PIPE_VR_FLUSH_EN` defined:
  - Adds `flush` input 1.
  - `flush=1` at an edge clears all `v[i]` and `count` to 0.
  - `d[i]` keep their values.
  - `in_ready` is forced to 0 while `flush=1`, so no input transfer occurs in that cycle.
  - An output transfer in that cycle still completes; `out_valid` is unaffected before the edge.
- Undefined: no `flush` port, and behaviour is as described above with no flush term.

## Test plan
- Reset then single push (WIDTH=8, DEPTH=3): `in_data=8'hA5` pushed at edge 1 with `out_ready=1` → `out_valid=1`, `out_data=8'hA5` after edge 3; `count` goes 1 then 0 after the pop.
- Streaming: push 0x01..0x10 on consecutive cycles with `out_ready=1` → outputs 0x01..0x10 in order, one per cycle with no gaps, `count` constant at 3 in steady state.
- Backpressure/fill: hold `out_ready=0` and push 0x11,0x22,0x33 → `count=3`, `in_ready=0`, `out_data=0x11` stable; raising `out_ready` with `in_valid` high pushes 0x44 and pops 0x11 in the same cycle, `count` stays 3.
- Bubble collapse: stall the output with one item in stage 2 and push again → new item advances to stage 1, then stage 0 fills; no item is lost and order is preserved.
- Async reset mid-stream: assert `async_rst_n=0` between edges with `count=2` → `out_valid=0`, `count=0`, `out_data=0` immediately; `in_ready=1`.
- Flush (`DFF_PIPE_VR_FLUSH_EN`): `count=3`, `flush=1`, `out_ready=1` → 0x11 popped at that edge, then `count=0` and `out_valid=0`; `in_ready=0` during the flush cycle.
